// File: rtl/cmd_response_checker.sv
// Checks a deserialized CMD-line response frame: serial CRC7 recompute (one bit per clock),
// framing-bit and index checks, then a one-cycle done strobe with the decoded fields.
module cmd_response_checker #(
  parameter int FRAME_W    = 136,
  parameter int SHORT_BITS = 40,
  parameter int LONG_BITS  = 120
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [FRAME_W-1:0] frame,
  input  logic               long_resp,
  input  logic               check_crc,
  input  logic               check_index,
  input  logic [5:0]         expected_index,
  output logic               busy,
  output logic               done,
  output logic               frame_error,
  output logic               crc_error,
  output logic               index_error,
  output logic [5:0]         resp_index,
  output logic [31:0]        resp_arg,
  output logic [119:0]       resp_long
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CRC   = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [6:0] SHORT_LAST = 7'(SHORT_BITS - 1);
  localparam logic [6:0] LONG_LAST  = 7'(LONG_BITS - 1);

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               long_q, long_d;
  logic               chk_crc_q, chk_crc_d;
  logic               chk_idx_q, chk_idx_d;
  logic [5:0]         exp_idx_q, exp_idx_d;
  logic [6:0]         crc_q, crc_d;
  logic [6:0]         cnt_q, cnt_d;

  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               frame_err_q, frame_err_d;
  logic               crc_err_q, crc_err_d;
  logic               idx_err_q, idx_err_d;
  logic [5:0]         resp_index_q, resp_index_d;
  logic [31:0]        resp_arg_q, resp_arg_d;
  logic [119:0]       resp_long_q, resp_long_d;

  logic               accept;
  logic [7:0]         bit_idx;
  logic               crc_bit;
  logic               fb;
  logic [6:0]         last_cnt;
  logic               start_bit;
  logic               tx_bit;
  logic               end_bit;
  logic [6:0]         rx_crc;
  logic [5:0]         rx_index;

  assign accept   = (state_q == IDLE) && start;
  assign bit_idx  = long_q ? (8'd127 - {1'b0, cnt_q}) : (8'd47 - {1'b0, cnt_q});
  assign crc_bit  = frame_q[bit_idx];
  assign fb       = crc_q[6] ^ crc_bit;
  assign last_cnt = long_q ? LONG_LAST : SHORT_LAST;

  // Framing fields sit at different MSB positions for the two response lengths.
  assign start_bit = long_q ? frame_q[135] : frame_q[47];
  assign tx_bit    = long_q ? frame_q[134] : frame_q[46];
  assign end_bit   = frame_q[0];
  assign rx_crc    = frame_q[7:1];
  assign rx_index  = frame_q[45:40];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      frame_q      <= '0;
      long_q       <= 1'b0;
      chk_crc_q    <= 1'b0;
      chk_idx_q    <= 1'b0;
      exp_idx_q    <= '0;
      crc_q        <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      crc_err_q    <= 1'b0;
      idx_err_q    <= 1'b0;
      resp_index_q <= '0;
      resp_arg_q   <= '0;
      resp_long_q  <= '0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      long_q       <= long_d;
      chk_crc_q    <= chk_crc_d;
      chk_idx_q    <= chk_idx_d;
      exp_idx_q    <= exp_idx_d;
      crc_q        <= crc_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      frame_err_q  <= frame_err_d;
      crc_err_q    <= crc_err_d;
      idx_err_q    <= idx_err_d;
      resp_index_q <= resp_index_d;
      resp_arg_q   <= resp_arg_d;
      resp_long_q  <= resp_long_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    long_d    = long_q;
    chk_crc_d = chk_crc_q;
    chk_idx_d = chk_idx_q;
    exp_idx_d = exp_idx_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          frame_d   = frame;
          long_d    = long_resp;
          chk_crc_d = check_crc;
          chk_idx_d = check_index;
          exp_idx_d = expected_index;
          crc_d     = '0;
          cnt_d     = '0;
          state_d   = CRC;
        end
      end
      CRC: begin
        // CRC7, polynomial x^7 + x^3 + 1, MSB-first
        crc_d = {crc_q[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == last_cnt) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy_d       = busy_q;
    done_d       = 1'b0;
    frame_err_d  = frame_err_q;
    crc_err_d    = crc_err_q;
    idx_err_d    = idx_err_q;
    resp_index_d = resp_index_q;
    resp_arg_d   = resp_arg_q;
    resp_long_d  = resp_long_q;
    if (accept) begin
      busy_d       = 1'b1;
      frame_err_d  = 1'b0;
      crc_err_d    = 1'b0;
      idx_err_d    = 1'b0;
      resp_index_d = '0;
      resp_arg_d   = '0;
      resp_long_d  = '0;
    end else if (state_q == CHECK) begin
      busy_d       = 1'b0;
      done_d       = 1'b1;
      frame_err_d  = start_bit | tx_bit | ~end_bit;
      crc_err_d    = chk_crc_q & (crc_q != rx_crc);
      idx_err_d    = chk_idx_q & ~long_q & (rx_index != exp_idx_q);
      resp_index_d = long_q ? 6'h3F : rx_index;
      resp_arg_d   = long_q ? 32'h0 : frame_q[39:8];
      resp_long_d  = long_q ? frame_q[127:8] : 120'h0;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign frame_error = frame_err_q;
  assign crc_error   = crc_err_q;
  assign index_error = idx_err_q;
  assign resp_index  = resp_index_q;
  assign resp_arg    = resp_arg_q;
  assign resp_long   = resp_long_q;

endmodule

// File: tb/tb_cmd_response_checker.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge monitor pops on done.
module tb_cmd_response_checker;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [135:0] frame;
  logic         long_resp;
  logic         check_crc;
  logic         check_index;
  logic [5:0]   expected_index;
  logic         busy;
  logic         done;
  logic         frame_error;
  logic         crc_error;
  logic         index_error;
  logic [5:0]   resp_index;
  logic [31:0]  resp_arg;
  logic [119:0] resp_long;

  cmd_response_checker dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .frame          (frame),
    .long_resp      (long_resp),
    .check_crc      (check_crc),
    .check_index    (check_index),
    .expected_index (expected_index),
    .busy           (busy),
    .done           (done),
    .frame_error    (frame_error),
    .crc_error      (crc_error),
    .index_error    (index_error),
    .resp_index     (resp_index),
    .resp_arg       (resp_arg),
    .resp_long      (resp_long)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           tid;
    int           c0;
    int           lat;
    logic         fe;
    logic         ce;
    logic         ie;
    logic [5:0]   idx;
    logic [31:0]  arg;
    logic [119:0] lng;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   dones  = 0;
  int   pushed = 0;

  // Hand-computed vectors
  localparam logic [135:0] F1    = 136'h110000090067;  // CMD17 R1, CRC7 0x33
  localparam logic [135:0] F1BAD = 136'h110000090069;  // CRC field 0x34
  localparam logic [135:0] LF    = 136'h3F89_0000_0000_0000_0000_0000_0000_00A5_BD;
  localparam logic [119:0] LLNG  = 120'h8900_0000_0000_0000_0000_0000_0000_A5;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && done === 1'b1) begin
      dones++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        $display("txn %0d done lat=%0d fe=%b ce=%b ie=%b idx=%0h arg=%0h",
                 e.tid, cyc - e.c0, frame_error, crc_error, index_error, resp_index, resp_arg);
        chk("latency", 128'(cyc - e.c0), 128'(e.lat));
        chk("busy_at_done", busy, 1'b0);
        chk("frame_error", frame_error, e.fe);
        chk("crc_error", crc_error, e.ce);
        chk("index_error", index_error, e.ie);
        chk("resp_index", resp_index, e.idx);
        chk("resp_arg", resp_arg, e.arg);
        chk("resp_long", resp_long, e.lng);
      end
    end
  end

  // Drives start for one edge, then scrambles the inputs to prove they were latched.
  task automatic issue(input int tid, input logic [135:0] f, input logic lr, input logic cc,
                       input logic ci, input logic [5:0] ei, input logic fe, input logic ce,
                       input logic ie, input logic [5:0] idx, input logic [31:0] arg,
                       input logic [119:0] lng, input bit push);
    exp_t e;
    frame          = f;
    long_resp      = lr;
    check_crc      = cc;
    check_index    = ci;
    expected_index = ei;
    start          = 1'b1;
    @(posedge clk);
    #1;
    start          = 1'b0;
    frame          = ~f;
    long_resp      = ~lr;
    check_crc      = ~cc;
    check_index    = ~ci;
    expected_index = ~ei;
    if (push) begin
      e.tid = tid;
      e.c0  = cyc;
      e.lat = lr ? 121 : 41;
      e.fe  = fe;
      e.ce  = ce;
      e.ie  = ie;
      e.idx = idx;
      e.arg = arg;
      e.lng = lng;
      sb.push_back(e);
      pushed++;
    end
    chk("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_done(input int lim);
    int n;
    n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL timeout_done actual=0 required=1 after %0d cycles", n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    reset          = 1'b1;
    start          = 1'b1;
    frame          = F1;
    long_resp      = 1'b0;
    check_crc      = 1'b1;
    check_index    = 1'b1;
    expected_index = 6'd17;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_flags", {frame_error, crc_error, index_error}, 3'b000);
    chk("rst_index", resp_index, 6'h0);
    chk("rst_arg", resp_arg, 32'h0);
    chk("rst_long", resp_long, 120'h0);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("start_in_reset_dropped", busy, 1'b0);

    // Valid R1, then a corrupted CRC accepted in the done cycle
    @(negedge clk);
    issue(1, F1, 1'b0, 1'b1, 1'b1, 6'd17, 1'b0, 1'b0, 1'b0, 6'd17, 32'h0000_0900, 120'h0, 1'b1);
    wait_done(200);
    issue(2, F1BAD, 1'b0, 1'b1, 1'b1, 6'd17, 1'b0, 1'b1, 1'b0, 6'd17, 32'h0000_0900, 120'h0, 1'b1);
    wait_done(200);

    // Index mismatch with junk above bit 47; bad tx bit; bad end bit; start bit set
    @(negedge clk);
    issue(3, {88'hDEADBEEF0123456789ABCD, 48'h110000090067}, 1'b0, 1'b1, 1'b1, 6'd18,
          1'b0, 1'b0, 1'b1, 6'd17, 32'h0000_0900, 120'h0, 1'b1);
    wait_done(200);
    @(negedge clk);
    issue(4, 136'h400000000095, 1'b0, 1'b1, 1'b1, 6'd0,
          1'b1, 1'b0, 1'b0, 6'd0, 32'h0, 120'h0, 1'b1);
    wait_done(200);
    @(negedge clk);
    issue(5, 136'h400000000094, 1'b0, 1'b1, 1'b1, 6'd0,
          1'b1, 1'b0, 1'b0, 6'd0, 32'h0, 120'h0, 1'b1);
    wait_done(200);
    @(negedge clk);
    issue(6, 136'h910000090067, 1'b0, 1'b1, 1'b1, 6'd17,
          1'b1, 1'b1, 1'b0, 6'd17, 32'h0000_0900, 120'h0, 1'b1);
    wait_done(200);

    // R3: CRC and index checks disabled
    @(negedge clk);
    issue(7, 136'h3F80FF8000FF, 1'b0, 1'b0, 1'b0, 6'd17,
          1'b0, 1'b0, 1'b0, 6'h3F, 32'h80FF_8000, 120'h0, 1'b1);
    wait_done(200);

    // Long R2, valid CRC (0x5E), index check suppressed for long
    @(negedge clk);
    issue(8, LF, 1'b1, 1'b1, 1'b1, 6'd5, 1'b0, 1'b0, 1'b0, 6'h3F, 32'h0, LLNG, 1'b1);
    wait_done(300);
    @(negedge clk);
    issue(9, LF ^ (136'd1 << 60), 1'b1, 1'b1, 1'b1, 6'd5,
          1'b0, 1'b1, 1'b0, 6'h3F, 32'h0, LLNG ^ (120'd1 << 52), 1'b1);
    wait_done(300);

    // Second start while busy is ignored
    @(negedge clk);
    issue(10, F1, 1'b0, 1'b1, 1'b1, 6'd17, 1'b0, 1'b0, 1'b0, 6'd17, 32'h0000_0900, 120'h0, 1'b1);
    repeat (9) @(negedge clk);
    issue(11, 136'h3F80FF8000FF, 1'b1, 1'b0, 1'b0, 6'd3,
          1'b0, 1'b0, 1'b0, 6'h0, 32'h0, 120'h0, 1'b0);
    wait_done(200);

    // Reset mid-operation aborts it
    @(negedge clk);
    issue(12, F1, 1'b0, 1'b1, 1'b1, 6'd17, 1'b0, 1'b0, 1'b0, 6'd17, 32'h0, 120'h0, 1'b0);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_flags", {frame_error, crc_error, index_error}, 3'b000);
    chk("midrst_outputs", {resp_index, resp_arg}, 38'h0);
    @(negedge clk);
    reset = 1'b0;
    seen  = 0;
    repeat (60) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    chk("no_done_after_reset", seen, 0);
    issue(13, F1, 1'b0, 1'b1, 1'b1, 6'd17, 1'b0, 1'b0, 1'b0, 6'd17, 32'h0000_0900, 120'h0, 1'b1);
    wait_done(200);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    chk("done_count", dones, pushed);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_response_checker.md
Name: cmd_response_checker

Overview:
- Downstream consumer of the CMD-line deserializer in src/cmd/communication.
- On the deserializer's complete pulse, latches the deserialized response frame.
- Recomputes CRC7 serially, one bit per clock, and checks the frame format, index and CRC.
- Presents the decoded fields and error flags to the command FSM with a one-cycle done strobe.

Parameters:
FRAME_W, 136, width of the frame input; must match the deserializer out width.
SHORT_BITS, 40, CRC-covered bits of a 48-bit response: frame[47:8].
LONG_BITS, 120, CRC-covered bits of a 136-bit R2 response: frame[127:8].

Ports:
clk  input  1  system clock; all state changes on rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  pulse from deserializer complete; frame is valid in the same cycle.
frame  input  136  deserialized response; first-received bit at frame[47] (short) or frame[135] (long).
long_resp  input  1  1 = 136-bit R2 response, 0 = 48-bit response; sampled with start.
check_crc  input  1  0 = skip CRC compare (R3); sampled with start.
check_index  input  1  1 = compare index field to expected_index; sampled with start.
expected_index  input  6  command index that was sent; sampled with start.
busy  output  1  high from the edge accepting start until the edge before done.
done  output  1  one-cycle strobe; results valid while done=1 and held until next start.
frame_error  output  1  start bit != 0, transmission bit != 0, or end bit != 1.
crc_error  output  1  computed CRC7 != received CRC7 (forced 0 if check_crc=0).
index_error  output  1  index mismatch (forced 0 if check_index=0 or long_resp=1).
resp_index  output  6  frame[45:40] (short); 6'h3F for long.
resp_arg  output  32  frame[39:8] (short); 0 for long.
resp_long  output  120  frame[127:8] (long); 0 for short.

Behaviour:
- Reset, async at any time including mid-operation:
  - state=IDLE, all outputs 0, CRC register 0, bit counter 0.
  - A start that coincides with reset is dropped.
- States: IDLE, CRC, CHECK.
- IDLE:
  - start=1 at edge E0: latch frame, long_resp, check_crc, check_index and expected_index.
  - Clear all error flags; crc<=0; cnt<=0; busy<=1; go to CRC.
- CRC:
  - Each edge consumes one bit, MSB-first: frame[47-cnt] (short) or frame[127-cnt] (long).
  - fb = crc[6] ^ bit; crc <= {crc[5:0],1'b0} ^ (fb ? 7'h09 : 7'h00). Polynomial x^7+x^3+1, init 0.
  - cnt increments each edge. After N bits (N=40 short, 120 long) go to CHECK.
- CHECK, one edge:
  - Register all result outputs and the error flags.
  - Short frame: start bit frame[47], tx bit frame[46], CRC frame[7:1], end bit frame[0].
  - Long frame: start bit frame[135], tx bit frame[134], CRC frame[7:1], end bit frame[0].
  - Set done<=1, busy<=0, return to IDLE.
- Timing:
  - done is high for exactly the one cycle following edge E0+N+1.
  - Latency from start to done is 41 clocks (short) and 121 clocks (long).
- start while busy=1 is ignored; the latched frame is not disturbed. start in the done cycle is accepted.
- Result outputs and flags hold their values until the next accepted start, which clears them.
- frame_error, crc_error and index_error are independent; several may be set together.

Test Plan:
1. Valid R1, CMD17 response: short frame = 48'h11_0000_0900_67, expected_index=17, check_crc=1, check_index=1 -> done 41 clocks after start; all errors 0; resp_index=17; resp_arg=32'h0000_0900.
2. Corrupted CRC, same frame with frame[7:0]=8'h69 -> crc_error=1, frame_error=0, index_error=0.
3. Index mismatch and bad tx bit:
   - Frame 1 with expected_index=18 -> index_error=1 only.
   - Frame 48'h40_0000_0000_95 -> frame_error=1 (tx bit=1).
   - Same frame with end bit cleared -> frame_error=1.
4. R3 mode: frame 48'h3F_80FF_8000_FF with check_crc=0, check_index=0 -> no errors; resp_arg=32'h80FF_8000.
5. Long R2: 136-bit frame with a valid CRC7 over bits [127:8] -> done 121 clocks after start; resp_long=frame[127:8]; resp_index=6'h3F; flipping frame[60] -> crc_error=1.
6. Control edges:
   - Second start pulse at clock 10 of an operation -> ignored; results match the first frame.
   - Reset pulsed at clock 20 -> busy=0, done never asserted, outputs 0; a subsequent start works normally.
